// File: rtl/simd_alu_subtractor_pipe_if.sv
// Operand/result bundle for the SIMD subtractor: valid/ready on both sides.
// master drives operands and out_ready; slave is the subtractor itself.
interface simd_alu_subtractor_pipe_if #(
   parameter int SIMD_DATA_WIDTH          = 256,
   parameter int SIMD_SUB_DATA_MODE_WIDTH = 2
);
   logic                                in_valid;
   logic                                in_ready;
   logic [SIMD_DATA_WIDTH-1:0]          a;
   logic [SIMD_DATA_WIDTH-1:0]          b;
   logic [SIMD_SUB_DATA_MODE_WIDTH-1:0] data_mode;
   logic                                data_signed;
   logic                                out_valid;
   logic                                out_ready;
   logic [SIMD_DATA_WIDTH-1:0]          result;
   logic [SIMD_DATA_WIDTH/8-1:0]        ovf;
   logic [SIMD_DATA_WIDTH/8-1:0]        udf;

   modport master (
      output in_valid, a, b, data_mode, data_signed, out_ready,
      input  in_ready, out_valid, result, ovf, udf
   );

   modport slave (
      input  in_valid, a, b, data_mode, data_signed, out_ready,
      output in_ready, out_valid, result, ovf, udf
   );
endinterface

// File: rtl/simd_alu_subtractor_pipe.sv
// Lane-wise a-b (8/16/32/64b lanes), per-byte ovf/udf; 2-cycle latency, 1 beat/cycle, in_ready drops only when both stages full and out_ready=0.
// Define SIMD_SUB_SATURATE_EN to clamp overflowing lanes instead of wrapping.
module simd_alu_subtractor_pipe #(
   parameter int SIMD_DATA_WIDTH          = 256,
   parameter int SIMD_SUB_DATA_MODE_WIDTH = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   simd_alu_subtractor_pipe_if.slave bus
);
   localparam int NB = SIMD_DATA_WIDTH / 8;

   typedef struct packed {
      logic [SIMD_DATA_WIDTH-1:0]          a;
      logic [SIMD_DATA_WIDTH-1:0]          b;
      logic [SIMD_SUB_DATA_MODE_WIDTH-1:0] mode;
      logic                                sgn;
   } opnd_t;

   opnd_t                      s1_dat;
   logic                       s1_valid;
   logic                       s2_valid;
   logic                       s1_rdy;
   logic                       s2_rdy;
   logic [SIMD_DATA_WIDTH-1:0] s2_result;
   logic [NB-1:0]              s2_ovf;
   logic [NB-1:0]              s2_udf;

   logic [3:0][SIMD_DATA_WIDTH-1:0] res_m;
   logic [3:0][NB-1:0]              ovf_m;
   logic [3:0][NB-1:0]              udf_m;
   logic [SIMD_DATA_WIDTH-1:0]      calc_res;
   logic [NB-1:0]                   calc_ovf;
   logic [NB-1:0]                   calc_udf;

   assign s2_rdy      = !s2_valid || bus.out_ready;
   assign s1_rdy      = !s1_valid || s2_rdy;
   assign bus.in_ready = s1_rdy;

   // One datapath per lane width; the registered mode picks which one reaches stage 2.
   for (genvar m = 0; m < 4; m++) begin : g_mode
      localparam int L  = 8 << m;
      localparam int N  = SIMD_DATA_WIDTH / L;
      localparam int LB = L / 8;

      for (genvar k = 0; k < N; k++) begin : g_lane
         logic [L-1:0] la;
         logic [L-1:0] lb;
         logic [L:0]   d;
         logic         s_ovf;
         logic         s_udf;
         logic         l_ovf;
         logic         l_udf;
         logic [L-1:0] l_res;

         assign la    = s1_dat.a[k*L +: L];
         assign lb    = s1_dat.b[k*L +: L];
         assign d     = {1'b0, la} - {1'b0, lb};
         assign s_ovf = !la[L-1] && lb[L-1] && d[L-1];
         assign s_udf = la[L-1] && !lb[L-1] && !d[L-1];
         assign l_ovf = s1_dat.sgn && s_ovf;
         assign l_udf = s1_dat.sgn ? s_udf : d[L];

`ifdef SIMD_SUB_SATURATE_EN
         always_comb begin
            l_res = d[L-1:0];
            if (l_udf) begin
               l_res = s1_dat.sgn ? {1'b1, {(L-1){1'b0}}} : '0;
            end else if (l_ovf) begin
               l_res = {1'b0, {(L-1){1'b1}}};
            end
         end
`else
         assign l_res = d[L-1:0];
`endif

         assign res_m[m][k*L +: L] = l_res;

         // Flags live in the lane's most significant byte only.
         for (genvar j = 0; j < LB; j++) begin : g_flag
            if (j == LB - 1) begin : g_top
               assign ovf_m[m][k*LB + j] = l_ovf;
               assign udf_m[m][k*LB + j] = l_udf;
            end else begin : g_low
               assign ovf_m[m][k*LB + j] = 1'b0;
               assign udf_m[m][k*LB + j] = 1'b0;
            end
         end
      end
   end

   // Encodings beyond 64-bit lanes leave everything at zero.
   always_comb begin
      calc_res = '0;
      calc_ovf = '0;
      calc_udf = '0;
      for (int m = 0; m < 4; m++) begin
         if (s1_dat.mode == SIMD_SUB_DATA_MODE_WIDTH'(m)) begin
            calc_res = res_m[m];
            calc_ovf = ovf_m[m];
            calc_udf = udf_m[m];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_dat   <= '0;
      end else if (s1_rdy) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_dat <= '{a: bus.a, b: bus.b, mode: bus.data_mode, sgn: bus.data_signed};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_ovf    <= '0;
         s2_udf    <= '0;
      end else if (s2_rdy) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= calc_res;
            s2_ovf    <= calc_ovf;
            s2_udf    <= calc_udf;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.result    = s2_result;
   assign bus.ovf       = s2_ovf;
   assign bus.udf       = s2_udf;
endmodule

// File: tb/tb_simd_alu_subtractor_pipe.sv
// Randomized and directed bench for simd_alu_subtractor_pipe against a range-based lane model.
module tb_simd_alu_subtractor_pipe;
   localparam int W  = 256;
   localparam int NB = W / 8;

   typedef struct {
      logic [W-1:0]  res;
      logic [NB-1:0] ovf;
      logic [NB-1:0] udf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ready_mode = 0;
   int   occ = 0;
   exp_t exp_q[$];
   logic [W-1:0]  last_res;
   logic [NB-1:0] last_ovf;
   logic [NB-1:0] last_udf;

   simd_alu_subtractor_pipe_if #(.SIMD_DATA_WIDTH(W), .SIMD_SUB_DATA_MODE_WIDTH(2)) bus ();

   simd_alu_subtractor_pipe #(.SIMD_DATA_WIDTH(W), .SIMD_SUB_DATA_MODE_WIDTH(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Exact difference in wide signed arithmetic, then range-checked against the lane's type.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                        input logic sgn, output exp_t e);
      int L;
      int lb;
      logic [63:0] mask, av, bv, lv;
      logic signed [65:0] as_v, bs_v, diff, maxv, minv;
      logic o, u;
      L    = 8 << mode;
      lb   = L / 8;
      mask = (L == 64) ? {64{1'b1}} : ((64'd1 << L) - 64'd1);
      e.res = '0;
      e.ovf = '0;
      e.udf = '0;
      for (int k = 0; k < W / L; k++) begin
         av   = 64'(a >> (k * L)) & mask;
         bv   = 64'(b >> (k * L)) & mask;
         as_v = {2'b00, av};
         bs_v = {2'b00, bv};
         if (sgn && av[L-1]) as_v = as_v - (66'sd1 <<< L);
         if (sgn && bv[L-1]) bs_v = bs_v - (66'sd1 <<< L);
         diff = as_v - bs_v;
         maxv = (66'sd1 <<< (L - 1)) - 66'sd1;
         minv = -(66'sd1 <<< (L - 1));
         if (sgn) begin
            o = diff > maxv;
            u = diff < minv;
         end else begin
            o = 1'b0;
            u = diff < 0;
         end
         lv = diff[63:0] & mask;
`ifdef SIMD_SUB_SATURATE_EN
         if (u) lv = sgn ? (64'd1 << (L - 1)) : 64'd0;
         else if (o) lv = (64'd1 << (L - 1)) - 64'd1;
`endif
         e.res = e.res | (W'(lv) << (k * L));
         e.ovf[(k + 1) * lb - 1] = o;
         e.udf[(k + 1) * lb - 1] = u;
      end
   endtask

   // Scoreboard and occupancy tracking, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         occ = 0;
      end else begin
         check("in_ready_rule", W'(bus.in_ready), W'(!(occ == 2 && !bus.out_ready)));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("result", bus.result, e.res);
               check("ovf", W'(bus.ovf), W'(e.ovf));
               check("udf", W'(bus.udf), W'(e.udf));
               last_res = bus.result;
               last_ovf = bus.ovf;
               last_udf = bus.udf;
            end
            occ--;
         end
         if (bus.in_valid && bus.in_ready) begin
            model(bus.a, bus.b, bus.data_mode, bus.data_signed, e);
            exp_q.push_back(e);
            occ++;
         end
      end
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the beat is taken.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                        input logic sgn);
      bit done = 0;
      bus.a           = a;
      bus.b           = b;
      bus.data_mode   = mode;
      bus.data_signed = sgn;
      bus.in_valid    = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1;
      end
      if (!done) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check("drain", W'(exp_q.size()), 0);
   endtask

   function automatic logic [W-1:0] rnd_vec();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [W-1:0] ta, tb;
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      bus.data_mode   = 2'd0;
      bus.data_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", W'(bus.in_ready), 1);
      check("rst_out_valid", W'(bus.out_valid), 0);
      check("rst_result", bus.result, 0);
      check("rst_ovf", W'(bus.ovf), 0);
      check("rst_udf", W'(bus.udf), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", W'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      // mode0 unsigned, no borrow anywhere; latency exactly 2
      drive({32{8'h10}}, {32{8'h01}}, 2'd0, 1'b0);
      check("lat1_out_valid", W'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check("lat2_out_valid", W'(bus.out_valid), 1);
      wait_drain();
      check("t1_res", last_res, {32{8'h0F}});
      check("t1_flags", W'({last_ovf, last_udf}), 0);

      // mode0 unsigned wrap in byte 0
      ta = '0;
      tb = '0;
      tb[7:0] = 8'h01;
      drive(ta, tb, 2'd0, 1'b0);
      wait_drain();
`ifdef SIMD_SUB_SATURATE_EN
      check("t2_res", last_res, 0);
`else
      check("t2_res", last_res, W'(8'hFF));
`endif
      check("t2_udf", W'(last_udf), 1);
      check("t2_ovf", W'(last_ovf), 0);

      // mode1 signed overflow in lane0, underflow in lane1
      ta = '0;
      tb = '0;
      ta[31:0] = 32'h8000_7FFF;
      tb[31:0] = 32'h0001_FFFF;
      drive(ta, tb, 2'd1, 1'b1);
      wait_drain();
`ifdef SIMD_SUB_SATURATE_EN
      check("t3_res", last_res, W'(32'h8000_7FFF));
`else
      check("t3_res", last_res, W'(32'h7FFF_8000));
`endif
      check("t3_ovf", W'(last_ovf), W'(32'h2));
      check("t3_udf", W'(last_udf), W'(32'h8));

      // mode3 unsigned borrow across a full 64-bit lane
      ta = '0;
      tb = '0;
      tb[0] = 1'b1;
      drive(ta, tb, 2'd3, 1'b0);
      wait_drain();
`ifdef SIMD_SUB_SATURATE_EN
      check("t4_res", last_res, 0);
`else
      check("t4_res", last_res, W'(64'hFFFF_FFFF_FFFF_FFFF));
`endif
      check("t4_udf", W'(last_udf), W'(32'h80));

      // streaming with random back-pressure
      ready_mode = 2;
      for (int i = 0; i < 16; i++) begin
         drive(rnd_vec(), rnd_vec(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 40; i++) begin
         drive(rnd_vec(), rnd_vec(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      ready_mode = 0;
      wait_drain();

      // fill both stages, then reset with them in flight
      ready_mode = 1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      drive(rnd_vec(), rnd_vec(), 2'd2, 1'b1);
      drive(rnd_vec(), rnd_vec(), 2'd0, 1'b0);
      check("bp_full_in_ready", W'(bus.in_ready), 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", W'(bus.out_valid), 0);
      check("mid_rst_result", bus.result, 0);
      check("mid_rst_flags", W'({bus.ovf, bus.udf}), 0);
      check("mid_rst_in_ready", W'(bus.in_ready), 1);
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("no_stale_beat", W'(bus.out_valid), 0);
      end
      drive(rnd_vec(), rnd_vec(), 2'd1, 1'b1);
      check("post_rst_lat1", W'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check("post_rst_lat2", W'(bus.out_valid), 1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
